encrypted_word_serializer: RTL and testbench

Downstream stage of the encrypter: accepts 78-bit encrypted words over a valid/ready handshake, buffers them, and emits each word as thirteen 6-bit symbols, MSB first, for the transmit link. Symbols leave over a second valid/ready handshake with first/last framing flags. A wrapping count of fully sent words is kept for link bookkeeping.

---
 rtl/cipher_link_pkg.sv | 8 +
 rtl/encrypted_word_serializer_if.sv | 20 ++
 rtl/word_fifo.sv | 34 +++
 rtl/encrypted_word_serializer.sv | 58 +++++
 tb/tb_encrypted_word_serializer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cipher_link_pkg.sv
// cipher_link_pkg: shared widths and FSM state type for the encrypted word serializer
package cipher_link_pkg;
  localparam int WORD_W = 78;
  localparam int SYM_W = 6;
  localparam int SYMS = WORD_W / SYM_W;
  localparam int IDX_W = $clog2(SYMS);
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/encrypted_word_serializer_if.sv
// encrypted_word_serializer_if: word input and symbol output handshakes
interface encrypted_word_serializer_if;
  import cipher_link_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [WORD_W-1:0] in_word;
  logic out_valid;
  logic out_ready;
  logic [SYM_W-1:0] out_sym;
  logic out_first;
  logic out_last;
  modport master (
    output in_valid, in_word, out_ready,
    input in_ready, out_valid, out_sym, out_first, out_last
  );
  modport slave (
    input in_valid, in_word, out_ready,
    output in_ready, out_valid, out_sym, out_first, out_last
  );
endinterface

// File: rtl/word_fifo.sv
// word_fifo: W x DEPTH synchronous FIFO exposing its head word and occupancy
module word_fifo #(
  parameter int W = 78,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [CW-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  always_ff @(posedge Clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= inc(wr);
      if (pop) rd <= inc(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rd];
endmodule

// File: rtl/encrypted_word_serializer.sv
// encrypted_word_serializer: buffers encrypted words and streams each as SYMS symbols, MSB first
module encrypted_word_serializer
  import cipher_link_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  encrypted_word_serializer_if.slave bus,
  output logic [15:0] words_sent
);
  localparam int CW = $clog2(DEPTH + 1);
  state_t state, state_n;
  logic [IDX_W-1:0] sym_idx, idx_n;
  logic [WORD_W-1:0] sh, sh_n, head;
  logic [15:0] ws_n;
  logic [CW-1:0] count, cnt_n;
  logic push, pop, hs, last;
  word_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .push(push),
    .pop(pop),
    .din(bus.in_word),
    .head(head),
    .count(count)
  );
  assign push = bus.in_valid && bus.in_ready;
  // the next head loads on the same edge as the final symbol leaves, so words run back to back
  always_comb begin
    hs = state == SEND && bus.out_ready;
    last = sym_idx == IDX_W'(SYMS - 1);
    pop = count != '0 && (state == IDLE || (hs && last));
    cnt_n = count + CW'(push) - CW'(pop);
    state_n = pop ? SEND : (hs && last) ? IDLE : state;
    idx_n = pop ? '0 : hs ? sym_idx + IDX_W'(1) : sym_idx;
    sh_n = pop ? head : hs ? sh << SYM_W : sh;
    ws_n = words_sent + 16'(hs && last);
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      sym_idx <= '0;
      sh <= '0;
      words_sent <= '0;
      bus.in_ready <= 1'b0;
    end else begin
      state <= state_n;
      sym_idx <= idx_n;
      sh <= sh_n;
      words_sent <= ws_n;
      bus.in_ready <= cnt_n < CW'(DEPTH);
    end
  assign bus.out_valid = state == SEND;
  assign bus.out_sym = bus.out_valid ? sh[WORD_W-1 -: SYM_W] : '0;
  assign bus.out_first = bus.out_valid && sym_idx == '0;
  assign bus.out_last = bus.out_valid && last;
endmodule

// File: tb/tb_encrypted_word_serializer.sv
// tb_encrypted_word_serializer: directed and randomized checks against a word-queue reference model
module tb_encrypted_word_serializer;
  import cipher_link_pkg::*;
  localparam int DEPTH = 2;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic [15:0] words_sent;
  int tests = 0;
  int fails = 0;
  encrypted_word_serializer_if bus();
  encrypted_word_serializer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .bus(bus),
    .words_sent(words_sent)
  );
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SYM_W-1:0] sym_of(input logic [WORD_W-1:0] w, input int i);
    return SYM_W'(w >> (WORD_W - SYM_W * (i + 1)));
  endfunction

  function automatic logic [WORD_W-1:0] rnd_word();
    return WORD_W'({$urandom, $urandom, $urandom});
  endfunction

  // reference model: accepted words in order, symbol position in the head word, words completed
  logic [WORD_W-1:0] word_q[$];
  int k = 0;
  logic [15:0] sent_cnt = 16'd0;
  logic [15:0] ws_off = 16'd0;
  logic prev_stall = 1'b0;
  logic [SYM_W+2:0] prev_out = '0;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      word_q.delete();
      k = 0;
      sent_cnt = 16'd0;
      prev_stall = 1'b0;
    end else begin
      check("words_sent", words_sent, 16'(sent_cnt + ws_off));
      if (prev_stall)
        check("hold", {bus.out_valid, bus.out_first, bus.out_last, bus.out_sym}, prev_out);
      if (bus.out_valid && bus.out_ready) begin
        if (word_q.size() == 0) check("spurious", bus.out_valid, 0);
        else begin
          check("sym", bus.out_sym, sym_of(word_q[0], k));
          check("first", bus.out_first, k == 0);
          check("last", bus.out_last, k == SYMS - 1);
          k++;
          if (k == SYMS) begin
            k = 0;
            void'(word_q.pop_front());
            sent_cnt++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) word_q.push_back(bus.in_word);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out = {bus.out_valid, bus.out_first, bus.out_last, bus.out_sym};
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [WORD_W-1:0] w, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_word = w;
    while (!ok && waited < 200) begin
      @(negedge Clk);
      ok = bus.in_ready;
      tick();
      if (!ok) waited++;
    end
    bus.in_valid = 1'b0;
    check("send_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((word_q.size() != 0 || bus.out_valid) && n < 2000);
    check("idle", word_q.size() == 0 && !bus.out_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    int wt, n;
    logic acc;
    logic [WORD_W-1:0] w, a, b, c, d;
    bus.in_valid = 1'b0;
    bus.in_word = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sym", bus.out_sym, 0);
    check("rst_first_last", {bus.out_first, bus.out_last}, 0);
    check("rst_words_sent", words_sent, 0);
    repeat (2) tick();
    check("rst_in_ready_held", bus.in_ready, 0);
    Rst_n = 1'b1;
    tick();
    check("in_ready_up", bus.in_ready, 1);

    // single word carrying symbols 1..13
    w = '0;
    for (int i = 0; i < SYMS; i++) w = (w << SYM_W) | WORD_W'(i + 1);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_word = w;
    @(negedge Clk);
    check("single_acc", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge Clk);
    check("latency_idle", bus.out_valid, 0);
    for (int i = 0; i < SYMS; i++) begin
      @(negedge Clk);
      check("single_sym", bus.out_sym, i + 1);
      check("single_valid", bus.out_valid, 1);
    end
    wait_idle();
    check("single_ws", words_sent, 1);

    // backpressure while symbol 4 is shown
    send(w, wt);
    n = 0;
    while (!(bus.out_valid && bus.out_sym == 4) && n < 50) begin
      tick();
      n++;
    end
    check("bp_found", bus.out_sym, 4);
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      check("bp_sym", bus.out_sym, 4);
      check("bp_valid", bus.out_valid, 1);
    end
    tick();
    bus.out_ready = 1'b1;
    @(negedge Clk);
    check("bp_release", bus.out_sym, 4);
    @(negedge Clk);
    check("bp_resume", bus.out_sym, 5);
    wait_idle();

    // fill: three words fit, the fourth waits
    bus.out_ready = 1'b0;
    a = rnd_word();
    b = rnd_word();
    c = rnd_word();
    d = rnd_word();
    send(a, wt);
    check("fill_a_wait", wt, 0);
    send(b, wt);
    check("fill_b_wait", wt, 0);
    send(c, wt);
    check("fill_c_wait", wt, 0);
    @(negedge Clk);
    check("fill_full", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_word = d;
    repeat (3) begin
      @(negedge Clk);
      check("fill_held", bus.in_ready, 0);
    end
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3 * SYMS; i++) begin
      @(negedge Clk);
      check("fill_contig", bus.out_valid, 1);
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) bus.in_valid = 1'b0;
    end
    check("fill_d_taken", bus.in_valid, 0);
    wait_idle();

    // push and pop on the same edge with one word in the FIFO
    bus.in_valid = 1'b1;
    bus.in_word = rnd_word();
    tick();
    bus.in_word = rnd_word();
    @(negedge Clk);
    check("pp_cnt_before", dut.u_fifo.count, 1);
    check("pp_idle_before", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    @(negedge Clk);
    check("pp_cnt_after", dut.u_fifo.count, 1);
    check("pp_in_ready", bus.in_ready, 1);
    check("pp_first", bus.out_first, 1);
    wait_idle();

    // reset during symbol 6 with two words queued
    bus.out_ready = 1'b0;
    a = rnd_word();
    send(a, wt);
    send(rnd_word(), wt);
    send(rnd_word(), wt);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("mid_at_sym6", bus.out_sym, sym_of(a, 5));
    Rst_n = 1'b0;
    ws_off = 16'd0;
    #1;
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_out_sym", bus.out_sym, 0);
    check("mid_first_last", {bus.out_first, bus.out_last}, 0);
    check("mid_in_ready", bus.in_ready, 0);
    check("mid_words_sent", words_sent, 0);
    repeat (2) tick();
    Rst_n = 1'b1;
    b = rnd_word();
    send(b, wt);
    @(negedge Clk);
    check("post_rst_idle", bus.out_valid, 0);
    @(negedge Clk);
    check("post_rst_sym0", bus.out_sym, sym_of(b, 0));
    check("post_rst_first", bus.out_first, 1);
    wait_idle();
    check("post_rst_ws", words_sent, 1);

    // counter wrap
    force dut.words_sent = 16'hFFFE;
    #1;
    release dut.words_sent;
    ws_off = 16'hFFFE - sent_cnt;
    send(rnd_word(), wt);
    wait_idle();
    check("wrap_ffff", words_sent, 16'hFFFF);
    send(rnd_word(), wt);
    wait_idle();
    check("wrap_0000", words_sent, 16'h0000);

    // randomized traffic against the model
    acc = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = $urandom_range(0, 3) != 0;
        bus.in_word = rnd_word();
      end
      bus.out_ready = (cyc / 200) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0;
      @(negedge Clk);
      acc = bus.in_valid && bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
